// File: rtl/if_stage_pkg.sv
// Shared CPU constants: fetch window, reset/exception vectors, exception codes.
// Values must stay identical to those used by CP0 and the MEM stage.
package if_stage_pkg;

    typedef logic [4:0] exc_code_t;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFC;

    localparam exc_code_t EXC_INT  = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;

    // RUN: normal fetch. ERET_WAIT: eret seen during a stall, return still owed.
    typedef enum logic {
        RUN       = 1'b0,
        ERET_WAIT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect/control inputs, instruction memory port and F outputs.
// master = the fetch stage, slave = the surrounding pipeline/memory.
interface if_stage_if;
    import if_stage_pkg::*;

    logic        En;
    logic        br_take;
    logic [31:0] br_target;
    logic        exc_enter;
    logic        eret;
    logic [31:0] epc;
    logic        bj_d;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic [31:0] PC4_F;
    logic [31:0] PC8_F;
    exc_code_t   ExcCode_F;
    logic        BJ_F;

    modport master (
        input  En, br_take, br_target, exc_enter, eret, epc, bj_d, imem_rdata,
        output imem_addr, Instr_F, PC_F, PC4_F, PC8_F, ExcCode_F, BJ_F
    );

    modport slave (
        output En, br_take, br_target, exc_enter, eret, epc, bj_d, imem_rdata,
        input  imem_addr, Instr_F, PC_F, PC4_F, PC8_F, ExcCode_F, BJ_F
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// PC register and next-PC priority mux; redirects visible right after the edge.
// Stall (i_en=0) holds the PC; an eret seen during a stall is remembered until release.
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RST  = PC_RESET,
    parameter logic [31:0] EXC_VEC = EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_br_take,
    input  logic [31:0] i_br_target,
    input  logic        i_exc_enter,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    output logic [31:0] o_pc
);

    pc_state_t   r_state;
    pc_state_t   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= PC_RST;
            r_state <= RUN;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        if (i_exc_enter) begin
            w_pc_nxt    = EXC_VEC;
            w_state_nxt = RUN;
        end else if (i_eret || (r_state == ERET_WAIT)) begin
            // epc is sampled on the releasing cycle, not when the eret arrived
            if (i_en) begin
                w_pc_nxt    = i_epc;
                w_state_nxt = RUN;
            end else begin
                w_state_nxt = ERET_WAIT;
            end
        end else if (!i_en) begin
            w_pc_nxt = r_pc;
        end else if (i_br_take) begin
            w_pc_nxt = i_br_target;
        end else begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: owns the PC, checks the fetch address, feeds the IF/ID register.
// All F outputs are combinational from the PC; stalls follow En shared with IF/ID.
module if_stage #(
    parameter logic [31:0] PC_RESET   = if_stage_pkg::PC_RESET,
    parameter logic [31:0] EXC_VECTOR = if_stage_pkg::EXC_VECTOR,
    parameter logic [31:0] IM_BASE    = if_stage_pkg::IM_BASE,
    parameter logic [31:0] IM_LIMIT   = if_stage_pkg::IM_LIMIT,
    parameter logic [4:0]  EXC_ADEL   = if_stage_pkg::EXC_ADEL
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    logic [31:0] w_pc;
    logic        w_adel;

    if_stage_pc_reg #(
        .PC_RST  (PC_RESET),
        .EXC_VEC (EXC_VECTOR)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .i_en        (bus.En),
        .i_br_take   (bus.br_take),
        .i_br_target (bus.br_target),
        .i_exc_enter (bus.exc_enter),
        .i_eret      (bus.eret),
        .i_epc       (bus.epc),
        .o_pc        (w_pc)
    );

    // Bad PCs are still presented so CP0 can capture them as EPC.
    assign w_adel = (w_pc[1:0] != 2'b00) || (w_pc < IM_BASE) || (w_pc > IM_LIMIT);

    assign bus.imem_addr = w_pc;
    assign bus.PC_F      = w_pc;
    assign bus.PC4_F     = w_pc + 32'd4;
    assign bus.PC8_F     = w_pc + 32'd8;
    assign bus.ExcCode_F = w_adel ? EXC_ADEL : 5'd0;
    assign bus.Instr_F   = w_adel ? 32'd0 : bus.imem_rdata;
    assign bus.BJ_F      = bus.bj_d;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for the fetch stage: table of cycles plus corner sequences.
module tb_if_stage;

    typedef struct {
        logic        rst;
        logic        en;
        logic        br;
        logic [31:0] tgt;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        bj;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic [4:0]  exp_exc;
    } vec_t;

    localparam logic [31:0] RD = 32'h2408_0001;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic en, logic br, logic [31:0] tgt,
                                logic exc, logic eret, logic [31:0] epc, logic bj,
                                logic [31:0] rdata, logic [31:0] exp_pc, logic [4:0] exp_exc);
        vec_t v;
        v.rst = rst; v.en = en; v.br = br; v.tgt = tgt; v.exc = exc; v.eret = eret;
        v.epc = epc; v.bj = bj; v.rdata = rdata; v.exp_pc = exp_pc; v.exp_exc = exp_exc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(vec_t v);
        reset          = v.rst;
        bus.En         = v.en;
        bus.br_take    = v.br;
        bus.br_target  = v.tgt;
        bus.exc_enter  = v.exc;
        bus.eret       = v.eret;
        bus.epc        = v.epc;
        bus.bj_d       = v.bj;
        bus.imem_rdata = v.rdata;
    endtask

    task automatic check_outputs(string tag, vec_t v);
        logic [31:0] exp_instr;
        exp_instr = (v.exp_exc != 5'd0) ? 32'd0 : v.rdata;
        chk({tag, " PC_F"},      bus.PC_F,       v.exp_pc);
        chk({tag, " PC4_F"},     bus.PC4_F,      v.exp_pc + 32'd4);
        chk({tag, " PC8_F"},     bus.PC8_F,      v.exp_pc + 32'd8);
        chk({tag, " imem_addr"}, bus.imem_addr,  v.exp_pc);
        chk({tag, " ExcCode_F"}, {27'd0, bus.ExcCode_F}, {27'd0, v.exp_exc});
        chk({tag, " Instr_F"},   bus.Instr_F,    exp_instr);
        chk({tag, " BJ_F"},      {31'd0, bus.BJ_F}, {31'd0, v.bj});
    endtask

    // Drive a cycle's inputs, take the edge, check the post-edge outputs.
    task automatic step(string tag, vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    initial begin
        vec_t tbl[$];

        // reset state: fields rst,en,br,tgt,exc,eret,epc,bj,rdata,exp_pc,exp_exc
        step("rst0", mk(1, 1, 0, 0, 0, 0, 0, 0, RD, 32'h3000, 0));
        step("rst1", mk(1, 1, 1, 32'h5000, 1, 1, 32'h3204, 1, RD, 32'h3000, 0));

        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h3004, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h3008, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h300C, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h3010, 0));
        tbl.push_back(mk(0, 0, 1, 32'h3100,     0, 0, 0,            0, RD, 32'h3010, 0));
        tbl.push_back(mk(0, 0, 1, 32'h3100,     0, 0, 0,            0, RD, 32'h3010, 0));
        tbl.push_back(mk(0, 1, 1, 32'h3100,     0, 0, 0,            0, RD, 32'h3100, 0));
        tbl.push_back(mk(0, 1, 1, 32'h3102,     0, 0, 0,            0, RD, 32'h3102, 4));
        tbl.push_back(mk(0, 1, 1, 32'h7000,     0, 0, 0,            0, RD, 32'h7000, 4));
        tbl.push_back(mk(0, 1, 1, 32'h2FFC,     0, 0, 0,            0, RD, 32'h2FFC, 4));
        tbl.push_back(mk(0, 1, 1, 32'h6FFC,     0, 0, 0,            0, 32'h1234_5678, 32'h6FFC, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h7000, 4));
        tbl.push_back(mk(0, 1, 1, 32'h3000,     0, 0, 0,            0, 32'h8C01_0000, 32'h3000, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 1, 32'h3204,     0, RD, 32'h4180, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 32'h3204,     0, RD, 32'h4184, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 1, 32'h3204,     0, RD, 32'h4184, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 32'h3204,     0, RD, 32'h4184, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 32'h3204,     0, RD, 32'h4184, 0));
        tbl.push_back(mk(0, 1, 1, 32'h3500,     0, 0, 32'h3204,     0, RD, 32'h3204, 0));
        tbl.push_back(mk(0, 1, 1, 32'h3500,     0, 1, 32'h3300,     0, RD, 32'h3300, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            1, RD, 32'h3304, 0));
        tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0,           0, RD, 32'hFFFF_FFFC, 4));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h0000_0000, 4));
        tbl.push_back(mk(0, 1, 0, 0,            0, 1, 32'h3206,     0, RD, 32'h3206, 4));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0, RD, 32'h320A, 4));

        foreach (tbl[i])
            step($sformatf("v%0d", i), tbl[i]);

        // reset mid-stream while an eret return is still owed
        step("mr0", mk(0, 1, 1, 32'h3400, 0, 0, 0,        0, RD, 32'h3400, 0));
        step("mr1", mk(0, 0, 0, 0,        0, 1, 32'h3204, 0, RD, 32'h3400, 0));
        step("mr2", mk(1, 1, 0, 0,        0, 0, 32'h3204, 0, RD, 32'h3000, 0));
        step("mr3", mk(0, 1, 0, 0,        0, 0, 32'h3204, 0, RD, 32'h3004, 0));

        // exception entry cancels an owed eret return
        step("ex0", mk(0, 0, 0, 0, 0, 1, 32'h3204, 0, RD, 32'h3004, 0));
        step("ex1", mk(0, 0, 0, 0, 1, 0, 32'h3204, 0, RD, 32'h4180, 0));
        step("ex2", mk(0, 1, 0, 0, 0, 0, 32'h3204, 0, RD, 32'h4184, 0));

        // owed return uses epc as seen on the releasing cycle
        step("ep0", mk(0, 0, 0, 0, 0, 1, 32'h5000, 0, RD, 32'h4184, 0));
        step("ep1", mk(0, 0, 0, 0, 0, 0, 32'h5554, 0, RD, 32'h4184, 0));
        step("ep2", mk(0, 1, 0, 0, 0, 0, 32'h3208, 0, RD, 32'h3208, 0));

        // BJ_F and Instr_F are combinational, no edge involved
        bus.bj_d = 1'b1;
        #1;
        chk("bj comb hi", {31'd0, bus.BJ_F}, 32'd1);
        bus.bj_d = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEC;
        #1;
        chk("bj comb lo", {31'd0, bus.BJ_F}, 32'd0);
        chk("instr comb", bus.Instr_F, 32'hDEAD_BEEC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
